// File: rtl/regfile_bank_8x16.sv
// Purpose: 8 x 16-bit register storage with one handshaked write port and a sequenced bulk-clear engine.
// Latency: accepted write visible on regs_out one cycle later; bulk clear takes exactly NUM_REGS cycles.
// Backpressure: wr_ready drops while clearing or when clr_start is asserted; stalled writes are not consumed.
// Build option: define REGBANK_R0_ZERO_EN to hardwire register 0 to zero (writes to it accepted, data dropped).
module regfile_bank_8x16 #(
   parameter int NUM_REGS = 8,
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              clr_start,
   output logic              busy,
   output logic              clr_done,
   output logic [DATA_W-1:0] regs_out [NUM_REGS-1:0],
   output logic [NUM_REGS-1:0] written_mask
);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] clr_idx;
   logic [ADDR_W-1:0] clr_idx_nxt;
   logic              done_nxt;
   logic              wr_fire;

   // A clear request in IDLE wins over a same-cycle write, so the write is held off.
   assign wr_ready = (state == IDLE) && !clr_start;
   assign wr_fire  = wr_valid && wr_ready;

   // Next-state: walk clr_idx 0..NUM_REGS-1 while clearing, pulse done on the last step.
   always_comb begin
      state_nxt   = state;
      clr_idx_nxt = clr_idx;
      done_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (clr_start) begin
               state_nxt   = CLEAR;
               clr_idx_nxt = '0;
            end
         end
         CLEAR: begin
            clr_idx_nxt = clr_idx + ADDR_W'(1);
            if (clr_idx == LAST_IDX) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // FSM state, clear index, and registered busy / done flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         clr_idx  <= '0;
         busy     <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         clr_idx  <= clr_idx_nxt;
         busy     <= (state_nxt == CLEAR);
         clr_done <= done_nxt;
      end
   end

   // Register storage: the clear engine zeroes one entry per cycle, otherwise accepted writes land.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_out[i] <= '0;
         end
         written_mask <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if ((state == CLEAR) && (clr_idx == ADDR_W'(i))) begin
               regs_out[i]     <= '0;
               written_mask[i] <= 1'b0;
            end else if (wr_fire && (wr_addr == ADDR_W'(i))) begin
               regs_out[i]     <= wr_data;
               written_mask[i] <= 1'b1;
            end
         end
`ifdef REGBANK_R0_ZERO_EN
         // Register 0 reads as constant zero; any write data aimed at it is dropped.
         regs_out[0]     <= '0;
         written_mask[0] <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_regfile_bank_8x16.sv
// Purpose: directed self-checking bench for regfile_bank_8x16.
// Latency: inputs driven 1 ns after the rising edge, outputs sampled before the next edge.
// Backpressure: exercises wr_ready stalls during clear and on clr_start collision.
module tb_regfile_bank_8x16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_valid;
   logic        wr_ready;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic        clr_start;
   logic        busy;
   logic        clr_done;
   logic [15:0] regs_out [7:0];
   logic [7:0]  written_mask;

   int errors = 0;
   int checks = 0;
   int busy_cycles;
   int done_seen;

`ifdef REGBANK_R0_ZERO_EN
   localparam logic [15:0] R0_FILL   = 16'h0000;
   localparam logic [15:0] R0_T6     = 16'h0000;
   localparam logic [7:0]  FILL_MASK = 8'hFE;
   localparam logic [7:0]  T6_MASK   = 8'h00;
`else
   localparam logic [15:0] R0_FILL   = 16'hFFFF;
   localparam logic [15:0] R0_T6     = 16'h1234;
   localparam logic [7:0]  FILL_MASK = 8'hFF;
   localparam logic [7:0]  T6_MASK   = 8'h01;
`endif

   regfile_bank_8x16 dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .clr_start    (clr_start),
      .busy         (busy),
      .clr_done     (clr_done),
      .regs_out     (regs_out),
      .written_mask (written_mask)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      wr_valid  = 1'b0;
      wr_addr   = 3'd0;
      wr_data   = 16'h0000;
      clr_start = 1'b0;
      repeat (2) tick();

      // T1: reset state
      chk("rst_mask", 16'(written_mask), 16'h0000);
      chk("rst_busy", 16'(busy), 16'h0000);
      chk("rst_done", 16'(clr_done), 16'h0000);
      chk("rst_r3", regs_out[3], 16'h0000);
      rst_n = 1'b1;
      #1;
      chk("rst_wr_ready", 16'(wr_ready), 16'h0001);

      // T2: single write, latency 1, no bypass
      wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 16'hA5A5;
      #1;
      chk("t2_ready", 16'(wr_ready), 16'h0001);
      chk("t2_no_bypass", regs_out[3], 16'h0000);
      tick();
      wr_valid = 1'b0;
      chk("t2_r3", regs_out[3], 16'hA5A5);
      chk("t2_mask", 16'(written_mask), 16'h0008);
      chk("t2_r2", regs_out[2], 16'h0000);

      // T3: back-to-back writes to the same address, last wins
      wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 16'h1111;
      tick();
      chk("t3_first", regs_out[5], 16'h1111);
      wr_data = 16'h2222;
      tick();
      wr_valid = 1'b0;
      chk("t3_second", regs_out[5], 16'h2222);
      chk("t3_mask", 16'(written_mask), 16'h0028);
      chk("t3_r3_hold", regs_out[3], 16'hA5A5);

      // T4: fill all, then sequenced clear
      for (int i = 0; i < 8; i++) begin
         wr_valid = 1'b1; wr_addr = 3'(i); wr_data = 16'hFFFF;
         tick();
      end
      wr_valid = 1'b0;
      chk("t4_fill_mask", 16'(written_mask), 16'(FILL_MASK));
      chk("t4_fill_r0", regs_out[0], R0_FILL);
      chk("t4_fill_r7", regs_out[7], 16'hFFFF);
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      wr_valid = 1'b1; wr_addr = 3'd7; wr_data = 16'h1234;
      #1;
      chk("t4_busy_ready", 16'(wr_ready), 16'h0000);
      busy_cycles = 0;
      for (int c = 0; c < 8; c++) begin
         if (busy) busy_cycles++;
         chk("t4_no_early_done", 16'(clr_done), 16'h0000);
         clr_start = (c == 3);
         tick();
         chk("t4_cleared", regs_out[c], 16'h0000);
         if (c < 7) chk("t4_not_yet", regs_out[c+1], 16'hFFFF);
      end
      clr_start = 1'b0;
      wr_valid  = 1'b0;
      chk("t4_busy_count", 16'(busy_cycles), 16'd8);
      chk("t4_busy_end", 16'(busy), 16'h0000);
      chk("t4_done", 16'(clr_done), 16'h0001);
      chk("t4_mask", 16'(written_mask), 16'h0000);
      chk("t4_r7_blocked", regs_out[7], 16'h0000);
      #1;
      chk("t4_ready_idle", 16'(wr_ready), 16'h0001);
      tick();
      chk("t4_done_pulse", 16'(clr_done), 16'h0000);
      chk("t4_no_restart", 16'(busy), 16'h0000);

      // T5: collision of clr_start with a write, then reset mid-clear
      wr_valid = 1'b1; wr_addr = 3'd6; wr_data = 16'h6666;
      tick();
      chk("t5_pre_mask", 16'(written_mask), 16'h0040);
      wr_addr = 3'd2; wr_data = 16'h00BE; clr_start = 1'b1;
      #1;
      chk("t5_coll_ready", 16'(wr_ready), 16'h0000);
      tick();
      wr_valid = 1'b0; clr_start = 1'b0;
      chk("t5_busy", 16'(busy), 16'h0001);
      chk("t5_r2_blocked", regs_out[2], 16'h0000);
      chk("t5_mask_blocked", 16'(written_mask), 16'h0040);
      repeat (4) tick();
      chk("t5_r6_pending", regs_out[6], 16'h6666);
      chk("t5_busy_mid", 16'(busy), 16'h0001);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_busy", 16'(busy), 16'h0000);
      chk("t5_rst_r6", regs_out[6], 16'h0000);
      chk("t5_rst_mask", 16'(written_mask), 16'h0000);
      chk("t5_rst_done", 16'(clr_done), 16'h0000);
      repeat (2) tick();
      rst_n = 1'b1;
      #1;
      chk("t5_ready_after", 16'(wr_ready), 16'h0001);
      done_seen = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (clr_done || busy) done_seen++;
      end
      chk("t5_no_done_pulse", 16'(done_seen), 16'd0);

      // T6: register 0 behaviour
      wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 16'h1234;
      #1;
      chk("t6_ready", 16'(wr_ready), 16'h0001);
      tick();
      wr_valid = 1'b0;
      chk("t6_r0", regs_out[0], R0_T6);
      chk("t6_mask", 16'(written_mask), 16'(T6_MASK));
      chk("t6_r1", regs_out[1], 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
